// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit common-anode FND scanner with frame-synchronous
// double buffering, dead time between digits and leading-zero blanking.
module fnd_scan_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int DEAD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] bcd,
  input  logic        load,
  input  logic        lzb,
  output logic [6:0]  fnd,
  output logic        fndsel1,
  output logic        fndsel2,
  output logic        fndsel3,
  output logic        fndsel4,
  output logic        busy,
  output logic        frame
);
  localparam int MX = TICK_DIV > DEAD ? TICK_DIV : DEAD;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] TL = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DL = CW'(DEAD == 0 ? 0 : DEAD - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t state, state_n;
  logic [1:0] dig, dig_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] pend, pend_n, disp, disp_n, cv;
  logic busy_n, show_end, gap_end, frame_end, frame_n;
  logic [3:0] sel, d;
  logic z3, z2, z1, blank, on;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
  endfunction

  assign show_end = state == SHOW && cnt == TL;
  assign gap_end = state == GAP && cnt == DL;
  assign frame_end = dig == 2'd3 && (DEAD == 0 ? show_end : gap_end);
  assign cv = load ? bcd : busy ? pend : disp;

  always_comb begin
    state_n = state;
    dig_n = dig;
    cnt_n = cnt;
    pend_n = pend;
    disp_n = disp;
    busy_n = busy;
    if (state == IDLE) begin
      disp_n = load ? bcd : disp;
      state_n = en ? SHOW : IDLE;
      dig_n = '0;
      cnt_n = '0;
    end else if (!en) begin
      state_n = IDLE;
      dig_n = '0;
      cnt_n = '0;
      disp_n = cv;
      busy_n = 1'b0;
    end else begin
      cnt_n = (show_end || gap_end) ? '0 : cnt + 1'b1;
      state_n = (show_end && DEAD != 0) ? GAP : gap_end ? SHOW : state;
      dig_n = (gap_end || (show_end && DEAD == 0)) ? dig + 1'b1 : dig;
      pend_n = load ? bcd : pend;
      busy_n = frame_end ? 1'b0 : (busy | load);
      disp_n = frame_end ? cv : disp;
    end
  end

  // Outputs are computed from the next-state values so they line up with the state register.
  assign d = disp_n[{dig_n, 2'b00} +: 4];
  assign z3 = disp_n[15:12] == 4'd0;
  assign z2 = z3 && disp_n[11:8] == 4'd0;
  assign z1 = z2 && disp_n[7:4] == 4'd0;
  assign blank = lzb && (dig_n == 2'd3 ? z3 : dig_n == 2'd2 ? z2 : dig_n == 2'd1 ? z1 : 1'b0);
  assign on = state_n == SHOW && !blank;
  assign frame_n = dig_n == 2'd3 && (DEAD == 0 ? (state_n == SHOW && cnt_n == TL) : (state_n == GAP && cnt_n == DL));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dig <= '0;
      cnt <= '0;
      pend <= '0;
      disp <= '0;
      busy <= 1'b0;
      frame <= 1'b0;
      fnd <= 7'h7F;
      sel <= 4'hF;
    end else begin
      state <= state_n;
      dig <= dig_n;
      cnt <= cnt_n;
      pend <= pend_n;
      disp <= disp_n;
      busy <= busy_n;
      frame <= frame_n;
      fnd <= on ? seg(d) : 7'h7F;
      sel <= on ? ~(4'b0001 << dig_n) : 4'hF;
    end
  end

  assign {fndsel4, fndsel3, fndsel2, fndsel1} = sel;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed and random stimulus against a scan-position reference model.
module tb_fnd_scan_ctrl;
  localparam int TD = 4;
  localparam int DD = 1;
  localparam int SLOT = TD + DD;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic load = 1'b0;
  logic lzb = 1'b0;
  logic [15:0] bcd = '0;
  logic [6:0] fnd;
  logic fndsel1, fndsel2, fndsel3, fndsel4, busy, frame;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_scan = 1'b0;
  int m_pos = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit m_busy = 1'b0;
  logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
                              7'h7F, 7'h7F, 7'h7F, 7'h7F};

  fnd_scan_ctrl #(.TICK_DIV(TD), .DEAD(DD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bcd(bcd), .load(load), .lzb(lzb),
    .fnd(fnd), .fndsel1(fndsel1), .fndsel2(fndsel2), .fndsel3(fndsel3),
    .fndsel4(fndsel4), .busy(busy), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(input int r, input int e, input int l, input int z, input logic [15:0] b);
    int k;
    logic [15:0] hi;
    logic [3:0] one;
    logic [3:0] e_sel;
    logic [6:0] e_fnd;
    bit sh, bl;
    rst_n = (r != 0);
    en = (e != 0);
    load = (l != 0);
    lzb = (z != 0);
    bcd = b;
    @(posedge clk);
    if (r == 0) begin
      m_scan = 1'b0; m_pos = 0; m_disp = '0; m_pend = '0; m_busy = 1'b0;
    end else if (!m_scan) begin
      if (l != 0) m_disp = b;
      m_scan = (e != 0);
      m_pos = 0;
    end else if (e == 0) begin
      m_disp = (l != 0) ? b : m_busy ? m_pend : m_disp;
      m_busy = 1'b0; m_scan = 1'b0; m_pos = 0;
    end else begin
      if (m_pos == FRAME - 1) begin
        m_disp = (l != 0) ? b : m_busy ? m_pend : m_disp;
        m_busy = 1'b0;
      end else if (l != 0) begin
        m_pend = b;
        m_busy = 1'b1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    @(negedge clk);
    k = m_pos / SLOT;
    sh = m_scan && (m_pos % SLOT) < TD;
    hi = m_disp >> (4 * k);
    bl = (z != 0) && k > 0 && hi == 16'd0;
    one = 4'b0001;
    e_sel = (sh && !bl) ? ~(one << k) : 4'hF;
    e_fnd = (sh && !bl) ? segtab[hi[3:0]] : 7'h7F;
    check("fnd", {9'd0, fnd}, {9'd0, e_fnd});
    check("sel", {12'd0, fndsel4, fndsel3, fndsel2, fndsel1}, {12'd0, e_sel});
    check("busy", {15'd0, busy}, {15'd0, m_busy});
    check("frame", {15'd0, frame}, {15'd0, m_scan && m_pos == FRAME - 1});
  endtask

  initial begin
    logic [15:0] rb;
    repeat (3) step(0, 0, 0, 0, '0);
    step(1, 0, 1, 0, 16'h1234);
    repeat (45) step(1, 1, 0, 0, '0);
    step(1, 1, 1, 0, 16'h0008);
    step(1, 1, 1, 0, 16'h0005);
    repeat (45) step(1, 1, 0, 0, '0);
    step(1, 1, 1, 1, 16'h0007);
    repeat (45) step(1, 1, 0, 1, '0);
    step(1, 1, 1, 1, 16'h0000);
    repeat (45) step(1, 1, 0, 1, '0);
    step(1, 1, 1, 0, 16'hFA90);
    repeat (45) step(1, 1, 0, 0, '0);
    for (int i = 0; i < 2 * FRAME && !(m_scan && m_pos == 2 * SLOT + 1); i++) step(1, 1, 0, 0, '0);
    check("dig2_sel", {15'd0, fndsel3}, 16'd0);
    step(1, 1, 1, 0, 16'h4321);
    step(1, 0, 0, 0, '0);
    repeat (3) step(1, 0, 0, 0, '0);
    repeat (25) step(1, 1, 0, 0, '0);
    step(1, 1, 1, 0, 16'h9999);
    check("busy_pre_rst", {15'd0, busy}, 16'd1);
    step(0, 1, 0, 0, '0);
    repeat (10) step(1, 1, 0, 0, '0);
    repeat (1500) begin
      for (int j = 0; j < 4; j++) rb[4*j +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 299) != 0) ? 1 : 0, ($urandom_range(0, 19) != 0) ? 1 : 0,
           ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 1)), rb);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
